line_shift_ram_param: RTL and testbench
=======================================

// Module: line_shift_ram_param
// PURPOSE
//   Parametrised multi-line buffer for 2-D window filters (Sobel, median, Gaussian) in the camera pipeline.
//   Stores the last NUM_TAPS lines of a raster stream and presents, for each incoming pixel, the pixels at
//   the same column in the NUM_TAPS previous lines, aligned with a delayed copy of the current pixel.
//   Adds frame-aware line counting, tap validity, line-length measurement and overflow detection.
// PARAMETERS
//   DATA_W      8   pixel width in bits
//   NUM_TAPS    2   number of previous lines output (1..4)
//   ADDR_W      10  column address width; max line length 2**ADDR_W pixels
//   LINE_CNT_W  11  width of line counter
// PORTS
//   clock            in   1                  system clock, all logic rising-edge
//   reset            in   1                  asynchronous, active-high reset
//   pre_frame_vsync  in   1                  frame sync; rising edge starts a new frame
//   pre_frame_href   in   1                  line active; low between lines
//   clken            in   1                  pixel strobe, qualified by pre_frame_href
//   shiftin          in   DATA_W             current pixel
//   post_clken       out  1                  output pixel strobe
//   post_cur         out  DATA_W             shiftin delayed to align with taps
//   taps             out  NUM_TAPS*DATA_W    [k*DATA_W +: DATA_W] = pixel k+1 lines above, same column
//   taps_valid       out  NUM_TAPS           bit k set when tap k holds data from the current frame
//   line_cnt         out  LINE_CNT_W         completed lines in current frame, saturating
//   line_len         out  ADDR_W+1           pixel count of last completed line
//   overflow         out  1                  sticky: a line exceeded 2**ADDR_W pixels this frame
// BEHAVIOUR
//   - Reset: all outputs 0, column address 0, line_cnt 0, overflow 0. RAM contents not reset.
//   - Storage: one inferred simple dual-port RAM, 2**ADDR_W words x NUM_TAPS*DATA_W. Word = tap stack.
//   - Pixel accepted when clken && pre_frame_href (accept). On accept: read word at col addr (cycle 0).
//     At cycle 1: write {word[(NUM_TAPS-1)*DATA_W-1:0], shiftin_d1} to the same addr (write port, addr_d1).
//   - Latency 1: post_clken = accept delayed 1; taps = RAM read data; post_cur = shiftin delayed 1.
//     post_clken, post_cur, taps are held at their last value when post_clken is 0.
//   - Column addr increments on each accept and returns to 0 when pre_frame_href is low.
//   - Wrap: when addr = 2**ADDR_W-1 and another accept arrives, addr holds, write suppressed, overflow set.
//   - Line end (href falling edge): if the line had >=1 accept, line_cnt++ (saturate at all-ones);
//     line_len <= accept count (saturates at 2**ADDR_W). A line with 0 accepts changes neither.
//   - Frame start (vsync rising edge): line_cnt <= 0, overflow <= 0; line_len held.
//     vsync edge and href falling edge in the same cycle: frame start wins, line_cnt = 0.
//   - taps_valid[k] = (line_cnt > k), registered in step with taps.
//   - Input requirement: pre_frame_href low for >= 2 cycles between lines (read/write address separation).
//     Back-to-back accepts within a line are supported every cycle; gaps in clken are allowed.
//   - Reset mid-line: pipeline flushed; next frame data valid after vsync; taps_valid 0 until lines fill.
// CONFIGURATION
//   LINE_SHIFT_ZERO_FILL_EN defined: taps lane k forced to 0 while taps_valid[k] = 0 (clean top border).
//   Not defined: taps lanes carry raw RAM content (stale previous-frame data until filled); taps_valid
//   still reported. No other difference.
// TESTING
//   - Reset release, no stimulus -> all outputs 0, overflow 0, line_cnt 0.
//   - DATA_W=8, NUM_TAPS=2, 3 lines x 8 px, pixel = line*16+col -> line 2 col 5: post_cur 8'h25,
//     tap0 8'h15, tap1 8'h05, taps_valid=2'b11, post_clken 1 cycle after clken.
//   - Line 1 of new frame after vsync -> taps_valid=2'b01, tap1=0 with ZERO_FILL_EN, stale without.
//   - clken toggled every other cycle, 640 px line -> line_len=640, output alignment preserved.
//   - ADDR_W=4, 20 px line -> overflow=1, line_len=16, addr 15 not overwritten; next vsync clears overflow.
//   - reset asserted mid-line 2 -> outputs 0 next edge; next frame counts from 0, taps_valid=0.

Source files
------------

// File: rtl/line_shift_ram_param_if.sv
// line_shift_ram_param_if: raster-in / tap-stack-out bundle for the line shift buffer.
// The master drives the video stream; the slave (the buffer) returns the aligned taps and status.
interface line_shift_ram_param_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_TAPS   = 2,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned LINE_CNT_W = 11
);
    logic                         pre_frame_vsync;
    logic                         pre_frame_href;
    logic                         clken;
    logic [DATA_W-1:0]            shiftin;
    logic                         post_clken;
    logic [DATA_W-1:0]            post_cur;
    logic [NUM_TAPS*DATA_W-1:0]   taps;
    logic [NUM_TAPS-1:0]          taps_valid;
    logic [LINE_CNT_W-1:0]        line_cnt;
    logic [ADDR_W:0]              line_len;
    logic                         overflow;

    modport master (
        output pre_frame_vsync, pre_frame_href, clken, shiftin,
        input  post_clken, post_cur, taps, taps_valid, line_cnt, line_len, overflow
    );

    modport slave (
        input  pre_frame_vsync, pre_frame_href, clken, shiftin,
        output post_clken, post_cur, taps, taps_valid, line_cnt, line_len, overflow
    );
endinterface

// File: rtl/line_shift_ram_param.sv
// line_shift_ram_param: multi-line buffer for 2-D window filters.
// One RAM word per column holds the stack of the NUM_TAPS previous pixels at that column.
// Each accepted pixel reads its column word (cycle 0), presents it as taps one cycle later and
// writes back the word shifted by one lane with the new pixel in lane 0 (cycle 1).
// Optional build macro: LINE_SHIFT_ZERO_FILL_EN forces tap lanes to zero until they hold
// data from the current frame.
module line_shift_ram_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_TAPS   = 2,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned LINE_CNT_W = 11
) (
    input  logic                   clock,
    input  logic                   reset,
    line_shift_ram_param_if.slave  bus
);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned WORD_W = NUM_TAPS * DATA_W;

    // Line buffer storage; deliberately not reset.
    logic [WORD_W-1:0]     r_mem [DEPTH];

    logic                  r_href_d1;
    logic                  r_vsync_d1;
    // Accepts in the current line; saturates at DEPTH, so the top bit doubles as "line full".
    logic [ADDR_W:0]       r_cnt;
    logic [LINE_CNT_W-1:0] r_line_cnt;
    logic [ADDR_W:0]       r_line_len;
    logic                  r_overflow;

    logic                  r_post_clken;
    logic [DATA_W-1:0]     r_cur;
    logic [WORD_W-1:0]     r_taps_raw;
    logic [NUM_TAPS-1:0]   r_taps_valid;
    logic                  r_wr_en;
    logic [ADDR_W-1:0]     r_wr_addr;

    logic                  w_accept;
    logic                  w_full;
    logic                  w_wr_ok;
    logic                  w_line_end;
    logic                  w_frame_start;
    logic [ADDR_W-1:0]     w_rd_addr;
    logic [WORD_W-1:0]     w_wr_word;
    logic [WORD_W-1:0]     w_taps;
    logic [NUM_TAPS-1:0]   w_valid_next;

    assign w_accept      = bus.clken && bus.pre_frame_href;
    assign w_full        = r_cnt[ADDR_W];
    // Once the line is full the address parks on the last column and writes stop.
    assign w_rd_addr     = w_full ? {ADDR_W{1'b1}} : r_cnt[ADDR_W-1:0];
    assign w_wr_ok       = w_accept && !w_full;
    assign w_line_end    = r_href_d1 && !bus.pre_frame_href;
    assign w_frame_start = bus.pre_frame_vsync && !r_vsync_d1;

    // Tap k is meaningful once at least k+1 lines of this frame have completed.
    always_comb begin
        w_valid_next = '0;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            w_valid_next[k] = (r_line_cnt > LINE_CNT_W'(k));
        end
    end

    // Write-back word: older lanes move up one line, the delayed pixel enters lane 0.
    generate
        if (NUM_TAPS > 1) begin : g_shift
            assign w_wr_word = {r_taps_raw[(NUM_TAPS-1)*DATA_W-1:0], r_cur};
        end else begin : g_single
            assign w_wr_word = r_cur;
        end
    endgenerate

    // Edge detectors and per-line column counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_href_d1  <= 1'b0;
            r_vsync_d1 <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_href_d1  <= bus.pre_frame_href;
            r_vsync_d1 <= bus.pre_frame_vsync;
            if (!bus.pre_frame_href) begin
                r_cnt <= '0;
            end else if (w_wr_ok) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Frame statistics: completed-line count, last line length, sticky overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_line_cnt <= '0;
            r_line_len <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_line_end && (r_cnt != '0)) begin
                r_line_len <= r_cnt;
            end
            if (w_frame_start) begin
                r_line_cnt <= '0;
            end else if (w_line_end && (r_cnt != '0) && (r_line_cnt != '1)) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end
            if (w_accept && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_frame_start) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Output stage: read data, delayed pixel and validity update together on accept, else hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_post_clken <= 1'b0;
            r_cur        <= '0;
            r_taps_raw   <= '0;
            r_taps_valid <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
        end else begin
            r_post_clken <= w_accept;
            r_wr_en      <= w_wr_ok;
            r_wr_addr    <= w_rd_addr;
            if (w_accept) begin
                r_cur        <= bus.shiftin;
                r_taps_raw   <= r_mem[w_rd_addr];
                r_taps_valid <= w_valid_next;
            end
        end
    end

    // RAM write port, one cycle behind the read of the same column.
    always_ff @(posedge clock) begin
        if (r_wr_en) begin
            r_mem[r_wr_addr] <= w_wr_word;
        end
    end

`ifdef LINE_SHIFT_ZERO_FILL_EN
    // Blank lanes that do not yet hold current-frame lines (clean top border).
    always_comb begin
        w_taps = r_taps_raw;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            if (!r_taps_valid[k]) begin
                w_taps[k*DATA_W +: DATA_W] = '0;
            end
        end
    end
`else
    assign w_taps = r_taps_raw;
`endif

    assign bus.post_clken = r_post_clken;
    assign bus.post_cur   = r_cur;
    assign bus.taps       = w_taps;
    assign bus.taps_valid = r_taps_valid;
    assign bus.line_cnt   = r_line_cnt;
    assign bus.line_len   = r_line_len;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_line_shift_ram_param.sv
// tb_line_shift_ram_param: two buffers (ADDR_W=10 and ADDR_W=4) fed the same raster stream and
// compared every cycle against a per-column pixel-history model, plus directed spot checks.
module tb_line_shift_ram_param;
    localparam int DW = 8;
    localparam int NT = 2;
    localparam int LW = 11;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    line_shift_ram_param_if #(.DATA_W(DW), .NUM_TAPS(NT), .ADDR_W(10), .LINE_CNT_W(LW)) bus0 ();
    line_shift_ram_param_if #(.DATA_W(DW), .NUM_TAPS(NT), .ADDR_W(4),  .LINE_CNT_W(LW)) bus1 ();

    line_shift_ram_param #(.DATA_W(DW), .NUM_TAPS(NT), .ADDR_W(10), .LINE_CNT_W(LW)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );
    line_shift_ram_param #(.DATA_W(DW), .NUM_TAPS(NT), .ADDR_W(4), .LINE_CNT_W(LW)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per DUT, per column, the pixels previously stored there (newest first).
    int  m_max [2] = '{1024, 16};
    int  m_hist [2][1024][NT];
    int  m_hn [2][1024];
    int  m_cnt [2];
    int  m_lcnt [2];
    int  m_llen [2];
    bit  m_ovf [2];
    bit  m_href_q;
    bit  m_vs_q;
    bit  e_pclk [2];
    int  e_cur [2];
    int  e_tap [2][NT];
    bit  e_known [2][NT];
    bit  e_valid [2][NT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_lcnt[d] = 0; m_llen[d] = 0; m_ovf[d] = 1'b0;
            e_pclk[d] = 1'b0; e_cur[d] = 0;
            for (int k = 0; k < NT; k++) begin
                e_tap[d][k] = 0; e_known[d][k] = 1'b1; e_valid[d][k] = 1'b0;
            end
        end
        m_href_q = 1'b0;
        m_vs_q   = 1'b0;
    endtask

    task automatic model_cycle(input bit vs, input bit hr, input bit ce, input int px);
        for (int d = 0; d < 2; d++) begin
            bit acc;
            bit full;
            bit ovf_set;
            int col;
            acc = ce && hr;
            ovf_set = 1'b0;
            e_pclk[d] = acc;
            if (acc) begin
                full = (m_cnt[d] >= m_max[d]);
                col  = full ? m_max[d] - 1 : m_cnt[d];
                e_cur[d] = px;
                for (int k = 0; k < NT; k++) begin
                    e_valid[d][k] = (m_lcnt[d] > k);
                    e_known[d][k] = !full && (k < m_hn[d][col]);
                    e_tap[d][k]   = m_hist[d][col][k];
`ifdef LINE_SHIFT_ZERO_FILL_EN
                    if (!e_valid[d][k]) begin
                        e_tap[d][k] = 0; e_known[d][k] = 1'b1;
                    end
`endif
                end
                if (!full) begin
                    for (int k = NT - 1; k > 0; k--) m_hist[d][col][k] = m_hist[d][col][k-1];
                    m_hist[d][col][0] = px;
                    if (m_hn[d][col] < NT) m_hn[d][col]++;
                    m_cnt[d]++;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            if (m_href_q && !hr && m_cnt[d] > 0) begin
                if (m_lcnt[d] < (1 << LW) - 1) m_lcnt[d]++;
                m_llen[d] = m_cnt[d];
            end
            if (!hr) m_cnt[d] = 0;
            if (vs && !m_vs_q) begin
                m_lcnt[d] = 0; m_ovf[d] = 1'b0;
            end
            if (ovf_set) m_ovf[d] = 1'b1;
        end
        m_href_q = hr;
        m_vs_q   = vs;
    endtask

    task automatic check_dut(input int d, input logic pclk, input logic [7:0] cur,
                             input logic [NT*DW-1:0] taps, input logic [NT-1:0] vld,
                             input logic [LW-1:0] lcnt, input logic [10:0] llen, input logic ovf);
        logic [NT-1:0] ev;
        chk($sformatf("d%0d post_clken", d), 32'(pclk), 32'(e_pclk[d]));
        chk($sformatf("d%0d post_cur", d), 32'(cur), 32'(e_cur[d]));
        for (int k = 0; k < NT; k++) begin
            ev[k] = e_valid[d][k];
            if (e_known[d][k]) begin
                chk($sformatf("d%0d tap%0d", d, k), 32'(taps[k*DW +: DW]), 32'(e_tap[d][k] & 255));
            end
        end
        chk($sformatf("d%0d taps_valid", d), 32'(vld), 32'(ev));
        chk($sformatf("d%0d line_cnt", d), 32'(lcnt), 32'(m_lcnt[d]));
        chk($sformatf("d%0d line_len", d), 32'(llen), 32'(m_llen[d]));
        chk($sformatf("d%0d overflow", d), 32'(ovf), 32'(m_ovf[d]));
    endtask

    task automatic check_all();
        check_dut(0, bus0.post_clken, bus0.post_cur, bus0.taps, bus0.taps_valid, bus0.line_cnt,
                  11'(bus0.line_len), bus0.overflow);
        check_dut(1, bus1.post_clken, bus1.post_cur, bus1.taps, bus1.taps_valid, bus1.line_cnt,
                  11'(bus1.line_len), bus1.overflow);
    endtask

    task automatic drive(input bit vs, input bit hr, input bit ce, input logic [7:0] px);
        bus0.pre_frame_vsync = vs; bus0.pre_frame_href = hr; bus0.clken = ce; bus0.shiftin = px;
        bus1.pre_frame_vsync = vs; bus1.pre_frame_href = hr; bus1.clken = ce; bus1.shiftin = px;
    endtask

    // One clock: apply inputs, advance past the edge, update model, compare.
    task automatic step(input bit vs, input bit hr, input bit ce, input logic [7:0] px);
        drive(vs, hr, ce, px);
        @(posedge clock);
        #1;
        model_cycle(vs, hr, ce, int'(px));
        check_all();
    endtask

    task automatic gap(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_start();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        gap(2);
    endtask

    // mode 0: clken every cycle, 1: every other cycle, 2: random gaps. rnd: random pixels.
    task automatic pixels(input int len, input int mode, input bit rnd, input int base,
                          input int start);
        int c = 0;
        bit t = 1'b0;
        while (c < len) begin
            bit ce;
            logic [7:0] px;
            if (mode == 0) ce = 1'b1;
            else if (mode == 1) begin t = ~t; ce = !t; end
            else ce = ($urandom_range(0, 3) != 0);
            px = rnd ? 8'($urandom_range(0, 255)) : 8'(base + start + c);
            step(1'b0, 1'b1, ce, px);
            if (ce) c++;
        end
    endtask

    task automatic do_reset(input int cycles);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        model_reset();
        repeat (cycles) begin
            @(posedge clock);
            #1;
            check_all();
        end
        reset = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        // Reset state and idle behaviour.
        do_reset(3);
        gap(3);

        // Frame A: 3 lines x 8 px, pixel = line*16 + col.
        frame_start();
        pixels(8, 0, 1'b0, 8'h00, 0); gap(3);
        pixels(8, 0, 1'b0, 8'h10, 0); gap(3);
        pixels(6, 0, 1'b0, 8'h20, 0);
        chk("A l2c5 post_clken", 32'(bus0.post_clken), 32'd1);
        chk("A l2c5 post_cur", 32'(bus0.post_cur), 32'h25);
        chk("A l2c5 tap0", 32'(bus0.taps[7:0]), 32'h15);
        chk("A l2c5 tap1", 32'(bus0.taps[15:8]), 32'h05);
        chk("A l2c5 taps_valid", 32'(bus0.taps_valid), 32'b11);
        pixels(2, 0, 1'b0, 8'h20, 6); gap(3);
        chk("A line_cnt", 32'(bus0.line_cnt), 32'd3);
        chk("A line_len", 32'(bus0.line_len), 32'd8);

        // Frame B: second line sees one valid tap; the other is blank or stale frame-A data.
        frame_start();
        chk("B line_cnt cleared", 32'(bus0.line_cnt), 32'd0);
        pixels(8, 0, 1'b0, 8'h30, 0); gap(3);
        pixels(4, 0, 1'b0, 8'h40, 0);
        chk("B l1c3 taps_valid", 32'(bus0.taps_valid), 32'b01);
        chk("B l1c3 tap0", 32'(bus0.taps[7:0]), 32'h33);
`ifdef LINE_SHIFT_ZERO_FILL_EN
        chk("B l1c3 tap1 blank", 32'(bus0.taps[15:8]), 32'h00);
`else
        chk("B l1c3 tap1 stale", 32'(bus0.taps[15:8]), 32'h23);
`endif
        pixels(4, 0, 1'b0, 8'h40, 4); gap(3);

        // Frame C: 640 px at half rate; the 16-column buffer overflows.
        frame_start();
        pixels(640, 1, 1'b0, 0, 0); gap(3);
        chk("C d0 line_len", 32'(bus0.line_len), 32'd640);
        chk("C d1 line_len", 32'(bus1.line_len), 32'd16);
        chk("C d0 overflow", 32'(bus0.overflow), 32'd0);
        chk("C d1 overflow", 32'(bus1.overflow), 32'd1);
        pixels(16, 0, 1'b0, 8'h80, 0);
        chk("C d1 col15 kept", 32'(bus1.taps[7:0]), 32'h0f);
        chk("C d0 col15", 32'(bus0.taps[7:0]), 32'h0f);
        pixels(4, 0, 1'b0, 8'h80, 16); gap(3);
        chk("C d1 overflow still set", 32'(bus1.overflow), 32'd1);
        frame_start();
        chk("C d1 overflow cleared", 32'(bus1.overflow), 32'd0);

        // Random frame: random lengths, clken gaps, pixels and blanking.
        for (int l = 0; l < 6; l++) begin
            pixels($urandom_range(1, 24), 2, 1'b1, 0, 0);
            gap($urandom_range(2, 4));
        end

        // Reset in the middle of line 2.
        frame_start();
        pixels(8, 0, 1'b1, 0, 0); gap(2);
        pixels(8, 0, 1'b1, 0, 0); gap(2);
        pixels(4, 0, 1'b1, 0, 0);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        do_reset(1);
        chk("R post_clken", 32'(bus0.post_clken), 32'd0);
        chk("R post_cur", 32'(bus0.post_cur), 32'd0);
        chk("R taps", 32'(bus0.taps), 32'd0);
        chk("R line_cnt", 32'(bus0.line_cnt), 32'd0);
        gap(2);
        frame_start();
        pixels(8, 0, 1'b1, 0, 0);
        chk("R new frame taps_valid", 32'(bus0.taps_valid), 32'd0);
        gap(3);
        chk("R new frame line_cnt", 32'(bus0.line_cnt), 32'd1);
        gap(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
